mem_access_unit: RTL and testbench

- Memory-stage consumer of the EX/MEM pipeline register outputs.
- Converts each registered load/store into a request/acknowledge transaction on the data-memory port, and generates store byte strobes.
- Formats load data with byte/halfword extraction and sign or zero extension.
- Stalls the pipeline until the transaction completes.
- Sits between the EX/MEM register and data memory; its load result feeds the writeback mux.

---
 rtl/mem_access_unit.sv | 199 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Memory-stage load/store sequencer: request/ack handshake, byte strobes, load formatting.
// Optional MEM_MISALIGN_TRAP_EN traps misaligned halfword/word accesses instead of issuing them.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] addr_in,
  input  logic [31:0] write_data_in,
  input  logic        data_write_en_in,
  input  logic        mem_read_en_in,
  input  logic [1:0]  data_men_write_command_in,
  input  logic [2:0]  load_gen_command_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        bus_error,
  output logic        misalign_err
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        req_q, req_d, we_q, we_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, load_q, load_d;
  logic [3:0]  strb_q, strb_d;
  logic        berr_q, berr_d, merr_q, merr_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  lcmd_q, lcmd_d;
  logic [1:0]  lane_q, lane_d;
  logic        access, mis, stall_c;

  function automatic logic [3:0] store_strb(input logic [1:0] cmd, input logic [1:0] a);
    case (cmd)
      2'b00:   return 4'b0001 << a;
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] cmd, input logic [31:0] d);
    case (cmd)
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] load_format(input logic [2:0] cmd, input logic [1:0] lane,
                                              input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = lane[1] ? rd[31:16] : rd[15:0];
    case (cmd)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b011:  return {24'b0, b};
      3'b100:  return {16'b0, h};
      default: return rd;
    endcase
  endfunction

  assign access = data_write_en_in | mem_read_en_in;

`ifdef MEM_MISALIGN_TRAP_EN
  function automatic logic misaligned(input logic st, input logic [1:0] scmd,
                                      input logic [2:0] lcmd, input logic [1:0] a);
    if (st) begin
      case (scmd)
        2'b00:   return 1'b0;
        2'b01:   return a[0];
        default: return a != 2'b00;
      endcase
    end
    case (lcmd)
      3'b000, 3'b011: return 1'b0;
      3'b001, 3'b100: return a[0];
      default:        return a != 2'b00;
    endcase
  endfunction

  assign mis = misaligned(data_write_en_in, data_men_write_command_in,
                          load_gen_command_in, addr_in[1:0]);
`else
  assign mis = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    load_d  = load_q;
    cnt_d   = cnt_q;
    lcmd_d  = lcmd_q;
    lane_d  = lane_q;
    berr_d  = 1'b0;
    merr_d  = 1'b0;
    stall_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          stall_c = 1'b1;
          if (mis) begin
            state_d = DONE;
            merr_d  = 1'b1;
            load_d  = '0;
          end else begin
            state_d = WAIT;
            req_d   = 1'b1;
            we_d    = data_write_en_in;
            addr_d  = {addr_in[31:2], 2'b00};
            wdata_d = store_data(data_men_write_command_in, write_data_in);
            strb_d  = data_write_en_in ?
                      store_strb(data_men_write_command_in, addr_in[1:0]) : 4'b0000;
            lcmd_d  = load_gen_command_in;
            lane_d  = addr_in[1:0];
            cnt_d   = '0;
          end
        end
      end
      WAIT: begin
        stall_c = 1'b1;
        cnt_d   = cnt_q + 16'd1;
        // A late ack on the final cycle still wins over the timeout.
        if (mem_ack) begin
          state_d = DONE;
          req_d   = 1'b0;
          if (!we_q) load_d = load_format(lcmd_q, lane_q, mem_rdata);
        end else if (cnt_q == TO_LAST) begin
          state_d = DONE;
          req_d   = 1'b0;
          load_d  = '0;
          berr_d  = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      load_q  <= '0;
      cnt_q   <= '0;
      lcmd_q  <= '0;
      lane_q  <= '0;
      berr_q  <= 1'b0;
      merr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      load_q  <= load_d;
      cnt_q   <= cnt_d;
      lcmd_q  <= lcmd_d;
      lane_q  <= lane_d;
      berr_q  <= berr_d;
      merr_q  <= merr_d;
    end
  end

  // Stall drops with reset even while upstream still presents a request.
  assign stall        = resetn & stall_c;
  assign mem_req      = req_q;
  assign mem_we       = we_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign mem_wstrb    = strb_q;
  assign load_data    = load_q;
  assign bus_error    = berr_q;
  assign misalign_err = merr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: default-timeout instance (a) and TIMEOUT_CYCLES=4 instance (b).
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] addr_in = '0, write_data_in = '0, mem_rdata = '0;
  logic [1:0]  scmd = '0;
  logic [2:0]  lcmd = '0;
  logic        we_a = 1'b0, re_a = 1'b0, we_b = 1'b0, re_b = 1'b0, mem_ack = 1'b0;

  logic        a_req, a_we, a_stall, a_berr, a_merr;
  logic [31:0] a_addr, a_wdata, a_ld;
  logic [3:0]  a_strb;
  logic        b_req, b_we, b_stall, b_berr, b_merr;
  logic [31:0] b_addr, b_wdata, b_ld;
  logic [3:0]  b_strb;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  mem_access_unit dut_a (
    .clk(clk), .resetn(resetn), .addr_in(addr_in), .write_data_in(write_data_in),
    .data_write_en_in(we_a), .mem_read_en_in(re_a),
    .data_men_write_command_in(scmd), .load_gen_command_in(lcmd),
    .mem_req(a_req), .mem_we(a_we), .mem_addr(a_addr), .mem_wdata(a_wdata),
    .mem_wstrb(a_strb), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .load_data(a_ld),
    .stall(a_stall), .bus_error(a_berr), .misalign_err(a_merr)
  );

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut_b (
    .clk(clk), .resetn(resetn), .addr_in(addr_in), .write_data_in(write_data_in),
    .data_write_en_in(we_b), .mem_read_en_in(re_b),
    .data_men_write_command_in(scmd), .load_gen_command_in(lcmd),
    .mem_req(b_req), .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wdata),
    .mem_wstrb(b_strb), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .load_data(b_ld),
    .stall(b_stall), .bus_error(b_berr), .misalign_err(b_merr)
  );

  bit sel = 1'b0;
  logic        o_req, o_we, o_stall, o_berr, o_merr;
  logic [31:0] o_addr, o_wdata, o_ld;
  logic [3:0]  o_strb;
  assign o_req   = sel ? b_req   : a_req;
  assign o_we    = sel ? b_we    : a_we;
  assign o_stall = sel ? b_stall : a_stall;
  assign o_berr  = sel ? b_berr  : a_berr;
  assign o_merr  = sel ? b_merr  : a_merr;
  assign o_addr  = sel ? b_addr  : a_addr;
  assign o_wdata = sel ? b_wdata : a_wdata;
  assign o_ld    = sel ? b_ld    : a_ld;
  assign o_strb  = sel ? b_strb  : a_strb;

  // Observations of the last transaction
  int          stall_n, req_n, berr_n;
  logic [31:0] addr_s, wdata_s, ld_done;
  logic [3:0]  strb_s;
  logic        we_s, stable, berr_done, merr_done, after_busy, done_seen;

  task automatic do_access(input bit s, input logic we, input logic re, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [1:0] sc, input logic [2:0] lc,
                           input logic [31:0] rd, input int ack_dly);
    stall_n = 0; req_n = 0; berr_n = 0; addr_s = '0; wdata_s = '0; strb_s = '0;
    we_s = 1'b0; stable = 1'b1; ld_done = '0; berr_done = 1'b0; merr_done = 1'b0;
    after_busy = 1'b0; done_seen = 1'b0;
    sel = s;
    @(posedge clk); #1;
    addr_in = addr; write_data_in = wd; scmd = sc; lcmd = lc; mem_rdata = rd; mem_ack = 1'b0;
    if (s) begin we_b = we; re_b = re; end else begin we_a = we; re_a = re; end
    for (int cyc = 0; cyc < 400 && !done_seen; cyc++) begin
      @(negedge clk);
      if (o_berr) berr_n++;
      if (o_stall) stall_n++;
      else if (cyc > 0) begin
        done_seen = 1'b1; ld_done = o_ld; berr_done = o_berr; merr_done = o_merr;
      end
      if (o_req) begin
        if (req_n == 0) begin
          addr_s = o_addr; wdata_s = o_wdata; strb_s = o_strb; we_s = o_we;
        end else if (o_addr !== addr_s || o_wdata !== wdata_s || o_strb !== strb_s || o_we !== we_s)
          stable = 1'b0;
        mem_ack = (req_n == ack_dly);
        req_n++;
      end else mem_ack = 1'b0;
    end
    mem_ack = 1'b0;
    we_a = 1'b0; re_a = 1'b0; we_b = 1'b0; re_b = 1'b0;
    @(negedge clk);
    after_busy = o_req | o_stall;
    if (o_berr) berr_n++;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({a_req, a_stall, a_berr, a_merr, a_strb} !== 8'h00) $display("FAIL reset_ctrl: got %b required 00000000", {a_req, a_stall, a_berr, a_merr, a_strb});
    else passes++;
    checks++;
    if (a_ld !== 32'h0 || a_addr !== 32'h0) $display("FAIL reset_data: load_data %h mem_addr %h required 0", a_ld, a_addr);
    else passes++;
    @(posedge clk); #3;
    resetn = 1'b1;
  endtask

  task automatic test_stores;
    do_access(1'b0, 1'b1, 1'b0, 32'h1003, 32'h000000AB, 2'b00, 3'b010, 32'h0, 0);
    checks++;
    if (addr_s !== 32'h1000 || strb_s !== 4'b1000 || wdata_s !== 32'hABABABAB || we_s !== 1'b1)
      $display("FAIL sb_bus: addr %h strb %b wdata %h we %b required 1000 1000 abababab 1", addr_s, strb_s, wdata_s, we_s);
    else passes++;
    checks++;
    if (stall_n !== 2 || req_n !== 1) $display("FAIL sb_timing: stall %0d req %0d required 2 1", stall_n, req_n);
    else passes++;
    checks++;
    if (after_busy !== 1'b0 || done_seen !== 1'b1) $display("FAIL sb_no_reissue: busy %b done %b required 0 1", after_busy, done_seen);
    else passes++;
    do_access(1'b0, 1'b1, 1'b0, 32'h1002, 32'h0000BEEF, 2'b01, 3'b010, 32'h0, 0);
    checks++;
    if (addr_s !== 32'h1000 || strb_s !== 4'b1100 || wdata_s !== 32'hBEEFBEEF)
      $display("FAIL sh_bus: addr %h strb %b wdata %h required 1000 1100 beefbeef", addr_s, strb_s, wdata_s);
    else passes++;
    do_access(1'b0, 1'b1, 1'b0, 32'h1004, 32'h11223344, 2'b10, 3'b010, 32'h0, 0);
    checks++;
    if (addr_s !== 32'h1004 || strb_s !== 4'b1111 || wdata_s !== 32'h11223344)
      $display("FAIL sw_bus: addr %h strb %b wdata %h required 1004 1111 11223344", addr_s, strb_s, wdata_s);
    else passes++;
  endtask

  typedef struct { logic [31:0] addr; logic [2:0] lc; logic [31:0] rd; logic [31:0] exp; } ld_vec_t;

  task automatic test_loads;
    ld_vec_t v[9];
    v[0] = '{32'h2000, 3'b000, 32'h123480FF, 32'hFFFFFFFF};
    v[1] = '{32'h2000, 3'b011, 32'h123480FF, 32'h000000FF};
    v[2] = '{32'h2001, 3'b000, 32'h123480FF, 32'hFFFFFF80};
    v[3] = '{32'h2003, 3'b011, 32'h123480FF, 32'h00000012};
    v[4] = '{32'h2002, 3'b001, 32'h123480FF, 32'h00001234};
    v[5] = '{32'h2000, 3'b001, 32'h00008001, 32'hFFFF8001};
    v[6] = '{32'h2000, 3'b100, 32'h00008001, 32'h00008001};
    v[7] = '{32'h2004, 3'b010, 32'h89ABCDEF, 32'h89ABCDEF};
    v[8] = '{32'h2008, 3'b111, 32'h13572468, 32'h13572468};
    for (int i = 0; i < 9; i++) begin
      do_access(1'b0, 1'b0, 1'b1, v[i].addr, 32'hFFFFFFFF, 2'b00, v[i].lc, v[i].rd, 0);
      checks++;
      if (ld_done !== v[i].exp) $display("FAIL load_%0d: load_data %h required %h", i, ld_done, v[i].exp);
      else passes++;
    end
    checks++;
    if (strb_s !== 4'b0000 || we_s !== 1'b0 || addr_s !== 32'h2008)
      $display("FAIL load_bus: strb %b we %b addr %h required 0000 0 2008", strb_s, we_s, addr_s);
    else passes++;
  endtask

  task automatic test_store_wins;
    do_access(1'b0, 1'b1, 1'b1, 32'h1001, 32'h0000005A, 2'b00, 3'b010, 32'hFFFFFFFF, 0);
    checks++;
    if (we_s !== 1'b1 || strb_s !== 4'b0010 || wdata_s !== 32'h5A5A5A5A)
      $display("FAIL store_wins_bus: we %b strb %b wdata %h required 1 0010 5a5a5a5a", we_s, strb_s, wdata_s);
    else passes++;
    checks++;
    if (ld_done !== 32'h13572468) $display("FAIL store_keeps_load: load_data %h required 13572468", ld_done);
    else passes++;
  endtask

  task automatic test_ack_delay;
    sel = 1'b0;
    @(posedge clk); #1;
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (a_req !== 1'b0 || a_stall !== 1'b0 || a_ld !== 32'h13572468)
      $display("FAIL stray_ack: req %b stall %b load %h required 0 0 13572468", a_req, a_stall, a_ld);
    else passes++;
    do_access(1'b0, 1'b0, 1'b1, 32'h4008, 32'h0, 2'b00, 3'b010, 32'hDEADBEEF, 5);
    checks++;
    if (req_n !== 6 || stable !== 1'b1 || addr_s !== 32'h4008)
      $display("FAIL delay_req: req cycles %0d stable %b addr %h required 6 1 4008", req_n, stable, addr_s);
    else passes++;
    checks++;
    if (stall_n !== 7 || ld_done !== 32'hDEADBEEF || after_busy !== 1'b0 || berr_n !== 0)
      $display("FAIL delay_done: stall %0d load %h busy %b berr %0d required 7 deadbeef 0 0", stall_n, ld_done, after_busy, berr_n);
    else passes++;
  endtask

  task automatic test_timeout;
    do_access(1'b1, 1'b0, 1'b1, 32'h6000, 32'h0, 2'b00, 3'b010, 32'h5555AAAA, 0);
    checks++;
    if (ld_done !== 32'h5555AAAA) $display("FAIL to_preload: load_data %h required 5555aaaa", ld_done);
    else passes++;
    do_access(1'b1, 1'b0, 1'b1, 32'h6004, 32'h0, 2'b00, 3'b010, 32'h0, -1);
    checks++;
    if (req_n !== 4 || stall_n !== 5) $display("FAIL to_timing: req %0d stall %0d required 4 5", req_n, stall_n);
    else passes++;
    checks++;
    if (berr_done !== 1'b1 || berr_n !== 1 || ld_done !== 32'h0 || after_busy !== 1'b0)
      $display("FAIL to_abort: berr %b pulses %0d load %h busy %b required 1 1 0 0", berr_done, berr_n, ld_done, after_busy);
    else passes++;
  endtask

  task automatic test_reset_mid;
    sel = 1'b0;
    @(posedge clk); #1;
    addr_in = 32'h5004; lcmd = 3'b010; re_a = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (a_req !== 1'b1 || a_stall !== 1'b1) $display("FAIL mid_wait: req %b stall %b required 1 1", a_req, a_stall);
    else passes++;
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (a_req !== 1'b0 || a_stall !== 1'b0 || a_addr !== 32'h0 || a_ld !== 32'h0)
      $display("FAIL mid_reset: req %b stall %b addr %h load %h required 0 0 0 0", a_req, a_stall, a_addr, a_ld);
    else passes++;
    re_a = 1'b0;
    @(posedge clk); #3;
    resetn = 1'b1;
    do_access(1'b0, 1'b0, 1'b1, 32'h5004, 32'h0, 2'b00, 3'b010, 32'h0BADF00D, 1);
    checks++;
    if (ld_done !== 32'h0BADF00D || req_n !== 2 || after_busy !== 1'b0)
      $display("FAIL post_reset_lw: load %h req %0d busy %b required 0badf00d 2 0", ld_done, req_n, after_busy);
    else passes++;
  endtask

  task automatic test_misalign;
    do_access(1'b0, 1'b0, 1'b1, 32'h3002, 32'h0, 2'b00, 3'b010, 32'hCAFEBABE, 0);
`ifdef MEM_MISALIGN_TRAP_EN
    checks++;
    if (req_n !== 0 || stall_n !== 1 || merr_done !== 1'b1 || ld_done !== 32'h0)
      $display("FAIL mis_lw: req %0d stall %0d merr %b load %h required 0 1 1 0", req_n, stall_n, merr_done, ld_done);
    else passes++;
`else
    checks++;
    if (req_n !== 1 || addr_s !== 32'h3000 || merr_done !== 1'b0 || ld_done !== 32'hCAFEBABE)
      $display("FAIL mis_lw: req %0d addr %h merr %b load %h required 1 3000 0 cafebabe", req_n, addr_s, merr_done, ld_done);
    else passes++;
`endif
    do_access(1'b0, 1'b0, 1'b1, 32'h2003, 32'h0, 2'b00, 3'b001, 32'h123480FF, 0);
`ifdef MEM_MISALIGN_TRAP_EN
    checks++;
    if (merr_done !== 1'b1 || ld_done !== 32'h0 || after_busy !== 1'b0)
      $display("FAIL mis_lh: merr %b load %h busy %b required 1 0 0", merr_done, ld_done, after_busy);
    else passes++;
`else
    checks++;
    if (merr_done !== 1'b0 || ld_done !== 32'h00001234 || after_busy !== 1'b0)
      $display("FAIL mis_lh: merr %b load %h busy %b required 0 00001234 0", merr_done, ld_done, after_busy);
    else passes++;
`endif
  endtask

  initial begin
    test_reset();
    test_stores();
    test_loads();
    test_store_wins();
    test_ack_delay();
    test_timeout();
    test_reset_mid();
    test_misalign();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
